// File: rtl/tt_timer_pkg.sv
// Shared constants for the tt_down_timer slice.
// Holds state encoding and default widths.
package tt_timer_pkg;

  localparam int TIMER_WIDTH = 4;
  localparam int TIMER_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/tt_timer_prescaler.sv
// Prescaler: tick every prescale+1 enabled clocks.
// Ports: clk, rst, en, clr, prescale -> tick.
module tt_timer_prescaler
  import tt_timer_pkg::*;
#(
  parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_cnt;

  // Compared against the live prescale input;
  // lowering prescale below presc_cnt wraps.
  assign tick = en && (presc_cnt == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (tick)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_down_timer.sv
// Loadable prescaled down-timer with done pulse.
// Ports: load/start/stop/auto_reload/prescale -> count, state, busy, done.
module tt_down_timer
  import tt_timer_pkg::*;
#(
  parameter int WIDTH      = TIMER_WIDTH,
  parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done
);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             presc_en;
  logic             tick;

  // Stop and load freeze the prescaler so a
  // resume continues the partial period.
  assign presc_en = (state_q == ST_RUN)
                  && !stop && !load;

  tt_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (presc_en),
    .clr      (load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        reload_q <= load_val;
        count_q  <= load_val;
        state_q  <= ST_IDLE;
      end else if (stop) begin
        if (state_q == ST_RUN)
          state_q <= ST_PAUSED;
      end else begin
        if (start && state_q != ST_RUN
            && count_q != '0)
          state_q <= ST_RUN;
        if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_q <= count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_q <= 1'b1;
            if (auto_reload && reload_q != '0) begin
              count_q <= reload_q;
            end else begin
              count_q <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
      end
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_tt_down_timer.sv
// Directed scoreboard bench for tt_down_timer.
// Expected outputs are queued per step and popped after the edge.
module tb_tt_down_timer;

  localparam int W  = 4;
  localparam int PW = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PAUS = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  load_val;
  logic          load, start, stop, auto_reload;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic [1:0]    state;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];

  tt_down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_val    (load_val),
    .load        (load),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .state       (state),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input int c,
                      input logic [1:0] s, input logic d);
    exp_t e;
    e.tag = tag;
    e.v = {c[3:0], s, (s == RUN), d};
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [7:0] got;
    e = sb.pop_front();
    got = {count, state, busy, done};
    checks++;
    assert (got === e.v) else begin
      errors++;
      $error("FAIL %s: got cnt=%0d st=%0d busy=%0b done=%0b expected cnt=%0d st=%0d busy=%0b done=%0b",
             e.tag, got[7:4], got[3:2], got[1], got[0],
             e.v[7:4], e.v[3:2], e.v[1], e.v[0]);
    end
  endtask

  task automatic step(input string tag, input int c,
                      input logic [1:0] s, input logic d);
    push(tag, c, s, d);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic now(input string tag, input int c,
                     input logic [1:0] s, input logic d);
    push(tag, c, s, d);
    compare();
  endtask

  initial begin
    rst = 1'b1;
    load_val = '0;
    load = 0; start = 0; stop = 0;
    auto_reload = 0;
    prescale = '0;
    #2;
    now("rst_init", 0, IDLE, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // one-shot, prescale 0
    load_val = 4'd3; load = 1;
    step("os_ld", 3, IDLE, 0);
    load = 0; start = 1;
    step("os_st", 3, RUN, 0);
    start = 0;
    step("os_2", 2, RUN, 0);
    step("os_1", 1, RUN, 0);
    step("os_done", 0, IDLE, 1);
    step("os_after", 0, IDLE, 0);

    // start with count 0 ignored
    start = 1;
    step("st_zero", 0, IDLE, 0);
    start = 0;
    step("st_zero2", 0, IDLE, 0);

    // prescale 2, pause and resume
    prescale = 8'd2;
    load_val = 4'd4; load = 1;
    step("ps_ld", 4, IDLE, 0);
    load = 0; start = 1;
    step("ps_st", 4, RUN, 0);
    start = 0;
    step("ps_a", 4, RUN, 0);
    step("ps_b", 4, RUN, 0);
    step("ps_dec", 3, RUN, 0);
    stop = 1;
    step("ps_stop", 3, PAUS, 0);
    stop = 0;
    for (int i = 0; i < 10; i++)
      step("ps_hold", 3, PAUS, 0);
    start = 1; stop = 1;
    step("ps_ststop", 3, PAUS, 0);
    stop = 0;
    step("ps_resume", 3, RUN, 0);
    start = 0;
    step("ps_r1", 3, RUN, 0);
    step("ps_r2", 3, RUN, 0);
    step("ps_t2", 2, RUN, 0);
    step("ps_r3", 2, RUN, 0);
    step("ps_r4", 2, RUN, 0);
    step("ps_t1", 1, RUN, 0);
    step("ps_r5", 1, RUN, 0);
    step("ps_r6", 1, RUN, 0);
    step("ps_done", 0, IDLE, 1);
    step("ps_after", 0, IDLE, 0);

    // auto-reload, prescale 0
    prescale = 8'd0;
    auto_reload = 1;
    load_val = 4'd2; load = 1;
    step("ar_ld", 2, IDLE, 0);
    load = 0; start = 1;
    step("ar_st", 2, RUN, 0);
    start = 0;
    step("ar_1a", 1, RUN, 0);
    step("ar_rl1", 2, RUN, 1);
    step("ar_1b", 1, RUN, 0);
    step("ar_rl2", 2, RUN, 1);
    auto_reload = 0;
    step("ar_1c", 1, RUN, 0);
    step("ar_end", 0, IDLE, 1);
    step("ar_after", 0, IDLE, 0);

    // load and start together: load wins
    load_val = 4'd7; load = 1; start = 1;
    step("ldst", 7, IDLE, 0);
    load = 0; start = 0;
    step("ldst_hold", 7, IDLE, 0);

    // reset mid-run
    prescale = 8'd3;
    load_val = 4'd5; load = 1;
    step("rm_ld", 5, IDLE, 0);
    load = 0; start = 1;
    step("rm_st", 5, RUN, 0);
    start = 0;
    step("rm_run", 5, RUN, 0);
    #2;
    rst = 1'b1;
    #1;
    now("rm_async", 0, IDLE, 0);
    step("rm_held", 0, IDLE, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      step("rm_nodone", 0, IDLE, 0);

    // 15 down to 0, no wrap
    prescale = 8'd0;
    load_val = 4'd15; load = 1;
    step("f_ld", 15, IDLE, 0);
    load = 0; start = 1;
    step("f_st", 15, RUN, 0);
    start = 0;
    for (int i = 14; i >= 1; i--)
      step("f_dec", i, RUN, 0);
    step("f_done", 0, IDLE, 1);
    step("f_nowrap", 0, IDLE, 0);
    step("f_nowrap2", 0, IDLE, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_down_timer.md
Name: tt_down_timer

Overview:
- Loadable, prescaled 4-bit down-counter/timer: the counting-down counterpart to the team's free-running up counter.
- Software-style control (load/start/stop) with a terminal-count `done` pulse and optional auto-reload.
- Sits behind the Tiny Tapeout top-level wrapper:
  - control inputs come from ui_in/uio_in;
  - count, busy and done drive uo_out.

Parameters:
- WIDTH, 4, width of count and load value.
- PRESCALE_W, 8, width of the prescale divider setting.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_val  input  WIDTH  value captured by load.
- load  input  1  level-sampled per cycle; loads count and reload register.
- start  input  1  begin/resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  on terminal count, reload and keep running.
- prescale  input  PRESCALE_W  tick every prescale+1 clocks while running.
- count  output  WIDTH  current counter value.
- state  output  2  IDLE=0, RUN=1, PAUSED=2 (3 unused, never produced).
- busy  output  1  high while state==RUN.
- done  output  1  one-cycle registered pulse at terminal count.

Behaviour:
- Reset (rst high, asynchronous):
  - count=0, reload_reg=0, presc_cnt=0, state=IDLE, busy=0, done=0.
  - Outputs hold these values while rst is high.
  - Reset mid-RUN aborts immediately and no done is produced.
- Priority per cycle is load > stop > start.
- load, in any state:
  - reload_reg<=load_val, count<=load_val, presc_cnt<=0, state<=IDLE, done<=0.
- start:
  - In IDLE or PAUSED with count!=0: state<=RUN.
  - With count==0: ignored, state unchanged, no done.
  - In RUN: no effect.
- stop:
  - In RUN: state<=PAUSED; count and presc_cnt are held.
  - Elsewhere: no effect.
  - start and stop together: stop wins (RUN->PAUSED, PAUSED stays).
- Prescaler, RUN only:
  - presc_cnt increments each cycle.
  - When presc_cnt==prescale: tick=1 and presc_cnt<=0.
  - prescale=0 gives a tick every RUN cycle.
  - presc_cnt is compared against the live prescale input; if prescale is lowered below presc_cnt, counting wraps through 2^PRESCALE_W (accepted, documented).
- On a tick with count>1: count<=count-1.
- Terminal tick (count==1):
  - auto_reload=1 and reload_reg!=0: count<=reload_reg, state stays RUN.
  - Otherwise: count<=0, state<=IDLE.
  - In both cases done<=1 for exactly one cycle, aligned with the new count value.
- done is 0 in all other cycles. It is never asserted by load, stop or reset.
- Latency example (prescale=0, load 3, start sampled at edge E):
  - count shows 3 after E, 2 after E+1, 1 after E+2, 0 after E+3.
  - done=1 only after E+3.
  - Total: N ticks from start to done.
- Arithmetic is unsigned, WIDTH bits. count never underflows below 0.
- busy is combinationally decoded from the state register (glitch-free, no extra latency).

Decomposition:
- Package tt_timer_pkg:
  - state encoding constants (ST_IDLE, ST_RUN, ST_PAUSED);
  - default WIDTH and PRESCALE_W.
- Sub-module tt_timer_prescaler:
  - inputs clk, rst, en (state==RUN), clr (load), prescale;
  - output tick.
- The top level holds the FSM, count, reload_reg and done.

Test Plan:
- Reset check: assert rst mid-RUN with count=5 -> same cycle, count=0, state=IDLE, busy=0, done=0; no done after release.
- One-shot, prescale=0: load_val=3, load, then start -> count 3,2,1,0 on consecutive edges; done high one cycle with count=0; state returns to IDLE.
- Prescale and pause, prescale=2: load 4, start -> decrement every 3 clocks.
  - stop after first decrement: count holds 3 for 10 cycles, state=PAUSED.
  - start again: resumes, done after remaining 3 ticks with no extra prescale restart.
- Auto-reload, prescale=0: auto_reload=1, load 2, start -> count 2,1,2,1,2...; done every 2 cycles; busy stays 1.
- Priority/boundaries:
  - start with count=0 -> no transition, no done.
  - load and start same cycle -> IDLE with new value.
  - start and stop same cycle from PAUSED -> stays PAUSED.
  - load_val=15 counts down through 0 with no wrap to 15.
